// File: rtl/alu_arbiter.sv
// Two-requester valid/ready arbiter around one external combinational ALU.
// Round-robin between requesters; define ALU_ARB_FIXED_PRIO_EN to give requester 0 fixed priority.
module alu_arbiter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned OP_W   = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req0_valid_i,
  output logic              req0_ready_o,
  input  logic [DATA_W-1:0] req0_op1_i,
  input  logic [DATA_W-1:0] req0_op2_i,
  input  logic [OP_W-1:0]   req0_alu_op_i,
  input  logic              req0_set_z_i,
  input  logic              req1_valid_i,
  output logic              req1_ready_o,
  input  logic [DATA_W-1:0] req1_op1_i,
  input  logic [DATA_W-1:0] req1_op2_i,
  input  logic [OP_W-1:0]   req1_alu_op_i,
  input  logic              req1_set_z_i,
  output logic [DATA_W-1:0] alu_op1_o,
  output logic [DATA_W-1:0] alu_op2_o,
  output logic [OP_W-1:0]   alu_opcode_o,
  input  logic [DATA_W-1:0] alu_result_i,
  input  logic              alu_zero_i,
  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic              resp_id_o,
  output logic [DATA_W-1:0] resp_result_o,
  output logic              resp_zero_o,
  output logic              z_flag_o,
  output logic              busy_o
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e              state_q;
  logic [DATA_W-1:0]   op1_q, op2_q, resp_result_q;
  logic [OP_W-1:0]     opc_q;
  logic                set_z_q, z_q;
  logic                resp_valid_q, resp_id_q, resp_zero_q;
  logic                gnt1, hs;
`ifndef ALU_ARB_FIXED_PRIO_EN
  logic                rr_q;
`endif

  // gnt1 selects requester 1; otherwise requester 0 owns the grant when it is valid.
  always_comb begin
    gnt1 = 1'b0;
`ifdef ALU_ARB_FIXED_PRIO_EN
    gnt1 = req1_valid_i & ~req0_valid_i;
`else
    gnt1 = req1_valid_i & (~req0_valid_i | rr_q);
`endif
    req0_ready_o = (state_q == StIdle) & req0_valid_i & ~gnt1;
    req1_ready_o = (state_q == StIdle) & gnt1;
    hs           = req0_ready_o | req1_ready_o;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= StIdle;
      op1_q         <= '0;
      op2_q         <= '0;
      opc_q         <= '0;
      set_z_q       <= 1'b0;
      z_q           <= 1'b0;
      resp_valid_q  <= 1'b0;
      resp_id_q     <= 1'b0;
      resp_result_q <= '0;
      resp_zero_q   <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
      rr_q          <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (hs) begin
            op1_q     <= gnt1 ? req1_op1_i    : req0_op1_i;
            op2_q     <= gnt1 ? req1_op2_i    : req0_op2_i;
            opc_q     <= gnt1 ? req1_alu_op_i : req0_alu_op_i;
            set_z_q   <= gnt1 ? req1_set_z_i  : req0_set_z_i;
            resp_id_q <= gnt1;
`ifndef ALU_ARB_FIXED_PRIO_EN
            rr_q      <= ~gnt1;
`endif
            state_q   <= StExec;
          end
        end
        StExec: begin
          resp_result_q <= alu_result_i;
          resp_zero_q   <= alu_zero_i;
          resp_valid_q  <= 1'b1;
          if (set_z_q) z_q <= alu_zero_i;
          state_q       <= StResp;
        end
        StResp: begin
          if (resp_ready_i) begin
            resp_valid_q <= 1'b0;
            state_q      <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign alu_op1_o     = op1_q;
  assign alu_op2_o     = op2_q;
  assign alu_opcode_o  = opc_q;
  assign resp_valid_o  = resp_valid_q;
  assign resp_id_o     = resp_id_q;
  assign resp_result_o = resp_result_q;
  assign resp_zero_o   = resp_zero_q;
  assign z_flag_o      = z_q;
  assign busy_o        = (state_q != StIdle);

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: directed scenarios followed by randomized traffic
// from both requesters, with the ALU modelled behaviourally around the DUT.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_op1 = '0, req0_op2 = '0, req1_op1 = '0, req1_op2 = '0;
  logic [3:0]  req0_alu_op = '0, req1_alu_op = '0;
  logic        req0_set_z = 1'b0, req1_set_z = 1'b0;
  logic [31:0] alu_op1, alu_op2, alu_result;
  logic [3:0]  alu_opcode;
  logic        alu_zero;
  logic        resp_valid, resp_ready = 1'b0, resp_id, resp_zero, z_flag, busy;
  logic [31:0] resp_result;

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    logic        id;
    logic [31:0] result;
    logic        zero;
    logic        z;
  } exp_t;

  exp_t sb[$];
  logic ids_seen[$];
  logic zmod = 1'b0;
  bit   rand_done = 0;

  always #5 clk = ~clk;

  // Reference ALU: AND, XOR, SUB, ADD, CMP (subtract), ORR; anything else yields 0.
  function automatic logic [31:0] alu_f(input logic [3:0] opc, input logic [31:0] a,
                                        input logic [31:0] b);
    case (opc)
      4'b0000: return a & b;
      4'b0001: return a ^ b;
      4'b0010: return a - b;
      4'b0100: return a + b;
      4'b1010: return a - b;
      4'b1100: return a | b;
      default: return 32'd0;
    endcase
  endfunction

  assign alu_result = alu_f(alu_opcode, alu_op1, alu_op2);
  assign alu_zero   = (alu_result == 32'd0);

  alu_arbiter #(.DATA_W(32), .OP_W(4)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req0_valid_i (req0_valid),
    .req0_ready_o (req0_ready),
    .req0_op1_i   (req0_op1),
    .req0_op2_i   (req0_op2),
    .req0_alu_op_i(req0_alu_op),
    .req0_set_z_i (req0_set_z),
    .req1_valid_i (req1_valid),
    .req1_ready_o (req1_ready),
    .req1_op1_i   (req1_op1),
    .req1_op2_i   (req1_op2),
    .req1_alu_op_i(req1_alu_op),
    .req1_set_z_i (req1_set_z),
    .alu_op1_o    (alu_op1),
    .alu_op2_o    (alu_op2),
    .alu_opcode_o (alu_opcode),
    .alu_result_i (alu_result),
    .alu_zero_i   (alu_zero),
    .resp_valid_o (resp_valid),
    .resp_ready_i (resp_ready),
    .resp_id_o    (resp_id),
    .resp_result_o(resp_result),
    .resp_zero_o  (resp_zero),
    .z_flag_o     (z_flag),
    .busy_o       (busy)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Present one request, hold it until accepted, then scramble the inputs.
  task automatic issue(input bit id, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] opc, input bit sz, input bit expect_resp);
    bit   got = 0;
    exp_t e;
    if (id == 1'b0) begin
      req0_op1 = a; req0_op2 = b; req0_alu_op = opc; req0_set_z = sz; req0_valid = 1'b1;
    end else begin
      req1_op1 = a; req1_op2 = b; req1_alu_op = opc; req1_set_z = sz; req1_valid = 1'b1;
    end
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if ((id ? req1_ready : req0_ready) === 1'b1) got = 1;
    end
    if (!got) begin
      n_checks++;
      n_err++;
      $display("FAIL accept_timeout: requester %0d got no ready, expected ready", id);
    end else if (expect_resp) begin
      e.id     = id;
      e.result = alu_f(opc, a, b);
      e.zero   = (e.result == 32'd0);
      if (sz) zmod = e.zero;
      e.z      = zmod;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    if (id == 1'b0) begin
      req0_valid = 1'b0; req0_op1 = $urandom; req0_op2 = $urandom;
      req0_alu_op = 4'($urandom); req0_set_z = 1'($urandom);
    end else begin
      req1_valid = 1'b0; req1_op1 = $urandom; req1_op2 = $urandom;
      req1_alu_op = 4'($urandom); req1_set_z = 1'($urandom);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && (sb.size() != 0 || resp_valid === 1'b1); i++) @(negedge clk);
    chk("drain_empty", 64'(sb.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: scoreboard pops, hold stability, and arbitration rules.
  initial begin : monitor
    logic        rr = 1'b0;
    logic        held = 1'b0;
    logic        p_id, p_zero;
    logic [31:0] p_res;
    logic        e0, e1;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        rr = 1'b0;
        held = 1'b0;
      end else begin
        if (held) begin
          chk("hold_valid", 64'(resp_valid), 64'd1);
          chk("hold_id", 64'(resp_id), 64'(p_id));
          chk("hold_result", 64'(resp_result), 64'(p_res));
          chk("hold_zero", 64'(resp_zero), 64'(p_zero));
        end
        held = 1'b0;
        if (resp_valid === 1'b1 && resp_ready === 1'b1) begin
          if (sb.size() == 0) begin
            chk("unexpected_resp", 64'(sb.size()), 64'd1);
          end else begin
            e = sb.pop_front();
            ids_seen.push_back(resp_id);
            chk("resp_id", 64'(resp_id), 64'(e.id));
            chk("resp_result", 64'(resp_result), 64'(e.result));
            chk("resp_zero", 64'(resp_zero), 64'(e.zero));
            chk("z_flag", 64'(z_flag), 64'(e.z));
          end
        end else if (resp_valid === 1'b1) begin
          held = 1'b1;
          p_id = resp_id; p_res = resp_result; p_zero = resp_zero;
        end
        if (busy === 1'b1) begin
          chk("ready_while_busy", {62'd0, req1_ready, req0_ready}, 64'd0);
        end else begin
`ifdef ALU_ARB_FIXED_PRIO_EN
          e0 = req0_valid;
`else
          e0 = req0_valid & (~req1_valid | ~rr);
`endif
          e1 = req1_valid & ~e0;
          if (req0_valid | req1_valid)
            chk("grant", {62'd0, req1_ready, req0_ready}, {62'd0, e1, e0});
          if (req0_valid && req0_ready) rr = 1'b1;
          if (req1_valid && req1_ready) rr = 1'b0;
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin : stim
    logic [31:0] a, b;
    logic        exp_ids [8];
    #3;
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_outputs", {resp_id, resp_zero, z_flag, busy, req0_ready, req1_ready},
        64'd0);
    chk("rst_alu", {alu_op1, alu_op2[27:0], alu_opcode}, 64'd0);
    chk("rst_result", 64'(resp_result), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    resp_ready = 1'b1;

    // Both requesters continuously valid straight after reset.
    ids_seen.delete();
    fork
      for (int i = 0; i < 4; i++) issue(0, 32'(i), 32'd1, 4'b0100, 0, 1);
      for (int i = 0; i < 4; i++) issue(1, 32'(i), 32'd2, 4'b0001, 0, 1);
    join
    drain();
    for (int i = 0; i < 8; i++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      exp_ids[i] = (i >= 4);
`else
      exp_ids[i] = i[0];
`endif
    end
    chk("rr_count", 64'(ids_seen.size()), 64'd8);
    for (int i = 0; i < 8 && i < ids_seen.size(); i++)
      chk($sformatf("grant_seq[%0d]", i), 64'(ids_seen[i]), 64'(exp_ids[i]));

    // ADD 5+7 with response latency check.
    issue(0, 32'd5, 32'd7, 4'b0100, 0, 1);
    @(posedge clk); #1;
    chk("latency_valid", 64'(resp_valid), 64'd1);
    chk("latency_result", 64'(resp_result), 64'd12);
    drain();

    // CMP sets Z, then SUB without set_z leaves it.
    issue(1, 32'd9, 32'd9, 4'b1010, 1, 1);
    drain();
    issue(0, 32'd9, 32'd4, 4'b0010, 0, 1);
    drain();

    // Backpressure in RESP with a pending requester 0.
    resp_ready = 1'b0;
    issue(0, 32'h1234, 32'h0F0F, 4'b0000, 0, 1);
    fork
      issue(0, 32'd100, 32'd1, 4'b0010, 0, 1);
      begin
        repeat (4) @(posedge clk);
        #1 resp_ready = 1'b1;
      end
    join
    drain();

    // Undefined opcode yields zero.
    issue(0, 32'd3, 32'd3, 4'b0111, 1, 1);
    drain();
    chk("undef_z", 64'(z_flag), 64'd1);

    // Reset during EXEC discards the op.
    issue(1, 32'hFFFF0000, 32'h0000FFFF, 4'b0001, 1, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_outputs", {resp_valid, resp_id, resp_zero, z_flag, busy}, 64'd0);
    chk("midrst_alu", {alu_op1, alu_op2}, 64'd0);
    chk("midrst_opc_res", {28'd0, alu_opcode, resp_result}, 64'd0);
    zmod = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("postrst_state", {resp_valid, z_flag, busy}, 64'd0);

    // Randomized traffic from both sides with random backpressure.
    fork
      begin
        fork
          for (int i = 0; i < 30; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            a = $urandom;
            issue(0, a, ($urandom_range(0, 3) == 0) ? a : 32'($urandom),
                  4'($urandom_range(0, 15)), 1'($urandom), 1);
          end
          for (int i = 0; i < 30; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            b = $urandom;
            issue(1, b, ($urandom_range(0, 3) == 0) ? b : 32'($urandom),
                  4'($urandom_range(0, 15)), 1'($urandom), 1);
          end
        join
        rand_done = 1;
      end
      while (!rand_done) begin
        @(posedge clk);
        #1 resp_ready = ($urandom_range(0, 3) != 0);
      end
    join
    resp_ready = 1'b1;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares the single combinational ALU (AND/XOR/SUB/ADD/CMP/ORR, 4-bit opcode, 32-bit operands, zero output) between two requesters. Requester 0 is the execute stage; requester 1 is the address/multi-cycle helper.
Arbitrates with valid/ready handshakes, drives the ALU from registered operands, and captures result and zero into a held response buffer.
Maintains the architectural Z flag for requests that ask to set flags.

Parameters:
DATA_W, 32, operand/result width
OP_W, 4, ALU opcode width

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
req0_valid  input  1  requester 0 has a request
req0_ready  output  1  requester 0 request accepted this cycle
req0_op1  input  DATA_W  requester 0 operand 1
req0_op2  input  DATA_W  requester 0 operand 2
req0_alu_op  input  OP_W  requester 0 ALU opcode
req0_set_z  input  1  requester 0 updates Z flag
req1_valid / req1_ready / req1_op1 / req1_op2 / req1_alu_op / req1_set_z  same as requester 0, for requester 1
alu_op1  output  DATA_W  to ALU op1
alu_op2  output  DATA_W  to ALU op2
alu_opcode  output  OP_W  to ALU alu_op
alu_result  input  DATA_W  from ALU result
alu_zero  input  1  from ALU zero
resp_valid  output  1  response available
resp_ready  input  1  consumer accepts response
resp_id  output  1  requester that owns the response
resp_result  output  DATA_W  captured result
resp_zero  output  1  captured zero
z_flag  output  1  architectural Z flag
busy  output  1  state != IDLE

Behaviour:
- Reset (async, rst_n=0): state IDLE; rr_ptr=0; z_flag=0; resp_valid=0; resp_id=0; resp_result=0; resp_zero=0; alu_op1/alu_op2/alu_opcode=0; busy=0; both req*_ready=0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant is computed combinationally. If only one req*_valid is high, that requester wins.
  - If both are high, the winner is rr_ptr (0 means requester 0).
  - reqN_ready=1 only for the winner, only in IDLE. Handshake = valid & ready.
  - On handshake: latch op1/op2/opcode/set_z/id into the ALU drive registers; rr_ptr <= ~winner; go to EXEC.
  - With no valid request, remain in IDLE.
- EXEC (exactly 1 cycle):
  - ALU inputs are stable from the registers.
  - At the clock edge: resp_result<=alu_result, resp_zero<=alu_zero, resp_valid<=1. Go to RESP.
  - If set_z was latched, z_flag<=alu_zero at the same edge.
- RESP:
  - Hold all resp_* stable while resp_valid & !resp_ready.
  - On resp_ready: resp_valid<=0 and go to IDLE.
  - No new request is accepted in that same cycle.
- Latency: handshake at edge N; resp_valid high after edge N+1. Throughput is at most one op per 3 cycles.
- Opcodes are passed through unmodified. Undefined opcodes give result 0 from the ALU, so resp_zero=1 (and z_flag=1 if set_z). This is not an error.
- Requester inputs are sampled only at the handshake. Changes afterwards do not affect the in-flight op.
- Requests are never dropped. A requester holding valid without ready simply waits.
- rr_ptr changes only on a handshake, so a lone requester does not starve the other.
- Reset mid-operation (EXEC or RESP): the transaction is discarded and all registers take their reset values. z_flag does not reflect the discarded op.

Optional Feature:
- Macro: ALU_ARB_FIXED_PRIO_EN.
- Defined: requester 0 always wins when both are valid. rr_ptr is not implemented, and requester 1 can starve.
- Undefined: round-robin as described above.

Test Plan:
1. req0: op1=5, op2=7, opcode 0100, set_z=0 -> req0_ready in IDLE; 2 edges later resp_valid=1, resp_id=0, resp_result=12, resp_zero=0; z_flag stays 0.
2. req1: CMP op1=9, op2=9, opcode 1010, set_z=1 -> resp_result=0, resp_zero=1, resp_id=1, z_flag=1. Then req0 SUB 9-4 with set_z=0 -> resp_result=5, z_flag remains 1.
3. Both requesters valid continuously after reset, resp_ready=1 -> grants alternate 0,1,0,1 (resp_id sequence). With ALU_ARB_FIXED_PRIO_EN -> 0,0,0,0.
4. resp_ready=0 for 3 cycles during RESP with a pending req0 -> resp_* stable, req0_ready=0 throughout; req0 is accepted only in the IDLE cycle after resp_ready=1.
5. rst_n asserted low during EXEC of XOR 0xFFFF0000^0x0000FFFF with set_z=1 -> all outputs 0 immediately (async); no resp_valid after release; z_flag=0.
6. Undefined opcode 0111, op1=3, op2=3, set_z=1 -> resp_result=0, resp_zero=1, z_flag=1.
